// File: rtl/m_render_tiles_if.sv
// Board renderer's view of the game state, the shared map RAMs and the VGA adapter.
// The master side is the renderer; the slave side is the surrounding system or bench.
interface m_render_tiles_if;
  logic       enable;
  logic       finished;
  logic [4:0] player_x;
  logic [3:0] player_y;
  logic [4:0] ghost1_x;
  logic [3:0] ghost1_y;
  logic [4:0] ghost2_x;
  logic [3:0] ghost2_y;
  logic [4:0] ghost3_x;
  logic [3:0] ghost3_y;
  logic       game_over;
  logic       you_won;
  logic [8:0] map_address;
  logic       wall_q;
  logic       food_q;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  modport master (
    input  enable, player_x, player_y, ghost1_x, ghost1_y, ghost2_x, ghost2_y,
           ghost3_x, ghost3_y, game_over, you_won, wall_q, food_q,
    output finished, map_address, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    output enable, player_x, player_y, ghost1_x, ghost1_y, ghost2_x, ghost2_y,
           ghost3_x, ghost3_y, game_over, you_won, wall_q, food_q,
    input  finished, map_address, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/m_render_tiles.sv
// Paints the tile board into the VGA framebuffer, one pixel per cycle, one frame per enable.
// Each tile costs ADDR + WAIT (map RAM latency) + TILE*TILE DRAW cycles.
module m_render_tiles #(
  parameter int COLUMNS  = 29,
  parameter int ROWS     = 15,
  parameter int TILE     = 4,
  parameter int X_OFFSET = 22,
  parameter int Y_OFFSET = 30
) (
  input logic            clock,
  input logic            resetn,
  m_render_tiles_if.master bus
);

  localparam int TB = $clog2(TILE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_ADDR,
    S_WAIT,
    S_DRAW,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [4:0]      tile_x_q, tile_x_d;
  logic [3:0]      tile_y_q, tile_y_d;
  logic [TB-1:0]   px_q, px_d;
  logic [TB-1:0]   py_q, py_d;
  logic [8:0]      addr_q, addr_d;
  logic [2:0]      tile_colour_q, tile_colour_d;
  logic            food_only_q, food_only_d;

  // Index 0 is the player, 1..3 are the ghosts.
  logic [4:0]      pos_x_in [4];
  logic [3:0]      pos_y_in [4];
  logic [4:0]      pos_x_q  [4];
  logic [3:0]      pos_y_q  [4];
  logic            game_over_q;
  logic            you_won_q;
  logic [3:0]      hit;

  logic            last_pixel;
  logic            last_col;
  logic            last_row;
  logic            centre;
  logic            plot;
  logic [7:0]      x_pix;
  logic [6:0]      y_pix;

  assign pos_x_in[0] = bus.player_x;
  assign pos_y_in[0] = bus.player_y;
  assign pos_x_in[1] = bus.ghost1_x;
  assign pos_y_in[1] = bus.ghost1_y;
  assign pos_x_in[2] = bus.ghost2_x;
  assign pos_y_in[2] = bus.ghost2_y;
  assign pos_x_in[3] = bus.ghost3_x;
  assign pos_y_in[3] = bus.ghost3_y;

  // Off-grid snapshots can never equal a tile counter, so they simply never match.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_hit
      assign hit[gi] = (pos_x_q[gi] == tile_x_q) && (pos_y_q[gi] == tile_y_q);
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) begin
        pos_x_q[i] <= '0;
        pos_y_q[i] <= '0;
      end
      game_over_q <= 1'b0;
      you_won_q   <= 1'b0;
    end else if (state_q == S_LATCH) begin
      for (int i = 0; i < 4; i++) begin
        pos_x_q[i] <= pos_x_in[i];
        pos_y_q[i] <= pos_y_in[i];
      end
      game_over_q <= bus.game_over;
      you_won_q   <= bus.you_won;
    end
  end

  assign last_pixel = (px_q == TB'(TILE - 1)) && (py_q == TB'(TILE - 1));
  assign last_col   = (tile_x_q == 5'(COLUMNS - 1));
  assign last_row   = (tile_y_q == 4'(ROWS - 1));

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      tile_x_q      <= '0;
      tile_y_q      <= '0;
      px_q          <= '0;
      py_q          <= '0;
      addr_q        <= '0;
      tile_colour_q <= '0;
      food_only_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      tile_x_q      <= tile_x_d;
      tile_y_q      <= tile_y_d;
      px_q          <= px_d;
      py_q          <= py_d;
      addr_q        <= addr_d;
      tile_colour_q <= tile_colour_d;
      food_only_q   <= food_only_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    tile_x_d      = tile_x_q;
    tile_y_d      = tile_y_q;
    px_d          = px_q;
    py_d          = py_q;
    addr_d        = addr_q;
    tile_colour_d = tile_colour_q;
    food_only_d   = food_only_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.enable) begin
          state_d  = S_LATCH;
          tile_x_d = '0;
          tile_y_d = '0;
          addr_d   = '0;
        end
      end
      S_LATCH: state_d = S_ADDR;
      S_ADDR:  state_d = S_WAIT;
      S_WAIT: begin
        // Map RAM data for the held address is valid in this cycle.
        state_d     = S_DRAW;
        px_d        = '0;
        py_d        = '0;
        food_only_d = 1'b0;
        if (hit[0]) begin
          tile_colour_d = 3'b110;
        end else if (|hit[3:1]) begin
          tile_colour_d = 3'b100;
        end else if (bus.wall_q) begin
          if (game_over_q)    tile_colour_d = 3'b100;
          else if (you_won_q) tile_colour_d = 3'b010;
          else                tile_colour_d = 3'b001;
        end else begin
          tile_colour_d = 3'b000;
          food_only_d   = bus.food_q;
        end
      end
      S_DRAW: begin
        px_d = px_q + 1'b1;
        if (px_q == TB'(TILE - 1)) begin
          py_d = py_q + 1'b1;
        end
        if (last_pixel) begin
          addr_d = addr_q + 1'b1;
          if (last_col) begin
            tile_x_d = '0;
            tile_y_d = tile_y_q + 1'b1;
          end else begin
            tile_x_d = tile_x_q + 1'b1;
          end
          state_d = (last_col && last_row) ? S_DONE : S_ADDR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign plot   = (state_q == S_DRAW);
  assign centre = (px_q == TB'(TILE / 2)) && (py_q == TB'(TILE / 2));
  assign x_pix  = 8'(X_OFFSET) + (8'(tile_x_q) << TB) + 8'(px_q);
  assign y_pix  = 7'(Y_OFFSET) + (7'(tile_y_q) << TB) + 7'(py_q);

  // Pixel outputs read zero whenever nothing is being plotted.
  assign bus.vga_plot    = plot;
  assign bus.finished    = (state_q == S_DONE);
  assign bus.map_address = addr_q;
  assign bus.vga_x       = plot ? x_pix : 8'd0;
  assign bus.vga_y       = plot ? y_pix : 7'd0;
  assign bus.vga_colour  = !plot       ? 3'b000 :
                           food_only_q ? (centre ? 3'b111 : 3'b000) :
                                         tile_colour_q;

endmodule

// File: tb/tb_m_render_tiles.sv
// Randomized frame-level bench for m_render_tiles: a reference painter builds the
// expected pixel stream per frame and every plotted pixel, timing and reset is checked.
module tb_m_render_tiles;

  localparam int COLS      = 29;
  localparam int ROWS      = 15;
  localparam int TILE      = 4;
  localparam int XO        = 22;
  localparam int YO        = 30;
  localparam int NT        = COLS * ROWS;
  localparam int FIN_CYCLE = 7832;
  localparam int PLOTS     = 6960;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  m_render_tiles_if bus();

  m_render_tiles #(
    .COLUMNS (COLS),
    .ROWS    (ROWS),
    .TILE    (TILE),
    .X_OFFSET(XO),
    .Y_OFFSET(YO)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  bit wall_mem [512];
  bit food_mem [512];

  always @(posedge clock) begin
    bus.wall_q <= wall_mem[bus.map_address];
    bus.food_q <= food_mem[bus.map_address];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int          sx [4];
  int          sy [4];
  bit          go;
  bit          yw;
  logic [31:0] expq[$];
  logic [31:0] first_exp;

  function automatic logic [2:0] ref_colour(input int tx, input int ty, input int px, input int py);
    int a;
    a = ty * COLS + tx;
    if (tx == sx[0] && ty == sy[0]) return 3'b110;
    for (int g = 1; g < 4; g++)
      if (tx == sx[g] && ty == sy[g]) return 3'b100;
    if (wall_mem[a]) return go ? 3'b100 : (yw ? 3'b010 : 3'b001);
    if (food_mem[a] && px == TILE / 2 && py == TILE / 2) return 3'b111;
    return 3'b000;
  endfunction

  task automatic build_expected();
    sx[0] = bus.player_x; sy[0] = bus.player_y;
    sx[1] = bus.ghost1_x; sy[1] = bus.ghost1_y;
    sx[2] = bus.ghost2_x; sy[2] = bus.ghost2_y;
    sx[3] = bus.ghost3_x; sy[3] = bus.ghost3_y;
    go = bus.game_over;
    yw = bus.you_won;
    expq.delete();
    for (int ty = 0; ty < ROWS; ty++)
      for (int tx = 0; tx < COLS; tx++)
        for (int py = 0; py < TILE; py++)
          for (int px = 0; px < TILE; px++)
            expq.push_back({5'b0, 9'(ty * COLS + tx), 8'(XO + tx * TILE + px),
                            7'(YO + ty * TILE + py), ref_colour(tx, ty, px, py)});
    first_exp = expq[0];
  endtask

  function automatic logic [31:0] observed();
    return {5'b0, bus.map_address, bus.vga_x, bus.vga_y, bus.vga_colour};
  endfunction

  function automatic logic [31:0] idle_outs();
    return {3'b0, bus.finished, bus.vga_plot, bus.map_address, bus.vga_x, bus.vga_y, bus.vga_colour};
  endfunction

  task automatic randomize_board(input bit gover, input bit won);
    for (int a = 0; a < 512; a++) begin
      wall_mem[a] = (a < NT) && ($urandom_range(0, 3) == 0);
      food_mem[a] = (a < NT) && !wall_mem[a] && ($urandom_range(0, 1) == 1);
    end
    bus.player_x = 5'($urandom_range(0, 31)); bus.player_y = 4'($urandom_range(0, 15));
    bus.ghost1_x = 5'($urandom_range(0, 31)); bus.ghost1_y = 4'($urandom_range(0, 15));
    bus.ghost2_x = 5'($urandom_range(0, 31)); bus.ghost2_y = 4'($urandom_range(0, 15));
    bus.ghost3_x = 5'($urandom_range(0, 31)); bus.ghost3_y = 4'($urandom_range(0, 15));
    bus.game_over = gover;
    bus.you_won   = won;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_frame(input string name, input bit hold, input int abort_at, input bit move_player);
    int n, plots, fin_at, fin_w, bad0, quiet, k;
    bad0 = n_bad;
    build_expected();
    bus.enable = 1'b1;
    @(posedge clock);
    n = 0; plots = 0; fin_at = 0; fin_w = 0;
    while (n < FIN_CYCLE + 200 && !(fin_at != 0 && n > fin_at)) begin
      @(negedge clock);
      n++;
      if (!hold && (!move_player || n == 100)) bus.enable = 1'b0;
      if (move_player && n == 100) bus.player_x = bus.player_x + 5'd7;
      if (n == abort_at) begin
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        check("abort_outs", idle_outs(), 32'd0);
        quiet = 0;
        repeat (40) begin
          @(negedge clock);
          quiet += int'(bus.vga_plot) + int'(bus.finished);
        end
        check("abort_quiet", quiet, 0);
        $display("frame %s: aborted at cycle %0d after %0d plots, new mismatches=%0d",
                 name, abort_at, plots, n_bad - bad0);
        return;
      end
      if (bus.vga_plot) begin
        plots++;
        if (expq.size() == 0) check("extra_plot", 1, 0);
        else check("pixel", observed(), expq.pop_front());
      end
      if (bus.finished) begin
        if (fin_at == 0) fin_at = n;
        fin_w++;
      end
    end
    check("finished_cycle", fin_at, FIN_CYCLE);
    check("finished_width", fin_w, 1);
    check("plot_count", plots, PLOTS);
    if (hold) begin
      k = 0;
      while (k < 20 && !bus.vga_plot) begin
        @(negedge clock);
        n++;
        k++;
      end
      check("restart_cycle", n, FIN_CYCLE + 5);
      check("restart_pixel", observed(), first_exp);
      bus.enable = 1'b0;
      resetn = 1'b0;
      @(negedge clock);
      resetn = 1'b1;
      check("hold_reset_outs", idle_outs(), 32'd0);
    end
    $display("frame %s: plots=%0d finished@%0d width=%0d new mismatches=%0d",
             name, plots, fin_at, fin_w, n_bad - bad0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tx, ty;
    bus.enable = 1'b0;
    bus.game_over = 1'b0;
    bus.you_won = 1'b0;
    bus.player_x = '0; bus.player_y = '0;
    bus.ghost1_x = '0; bus.ghost1_y = '0;
    bus.ghost2_x = '0; bus.ghost2_y = '0;
    bus.ghost3_x = '0; bus.ghost3_y = '0;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    check("reset_outs", idle_outs(), 32'd0);
    repeat (2) @(negedge clock);
    check("idle_outs", idle_outs(), 32'd0);

    // Empty board, fixed actors; enable held to check back-to-back restart.
    bus.player_x = 5'd1;  bus.player_y = 4'd1;
    bus.ghost1_x = 5'd5;  bus.ghost1_y = 4'd5;
    bus.ghost2_x = 5'd13; bus.ghost2_y = 4'd5;
    bus.ghost3_x = 5'd21; bus.ghost3_y = 4'd5;
    run_frame("empty_board", 1'b1, 0, 1'b0);

    randomize_board(1'b0, 1'b0);
    run_frame("reset_abort", 1'b0, 3000, 1'b0);

    // Restart after abort: wall at 0, food at 1, player and ghost1 on one wall tile, player moved mid-frame.
    randomize_board(1'b0, 1'b0);
    wall_mem[0] = 1'b1; food_mem[0] = 1'b0;
    wall_mem[1] = 1'b0; food_mem[1] = 1'b1;
    tx = $urandom_range(2, COLS - 1);
    ty = $urandom_range(0, ROWS - 1);
    wall_mem[ty * COLS + tx] = 1'b1;
    bus.player_x = 5'(tx); bus.player_y = 4'(ty);
    bus.ghost1_x = 5'(tx); bus.ghost1_y = 4'(ty);
    run_frame("walls_food", 1'b0, 0, 1'b1);

    randomize_board(1'b1, 1'b0);
    run_frame("game_over", 1'b0, 0, 1'b0);
    randomize_board(1'b0, 1'b1);
    run_frame("you_won", 1'b0, 0, 1'b0);
    randomize_board(1'b1, 1'b1);
    run_frame("both_flags", 1'b0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
